// File: rtl/render_scheduler_pkg.sv
// render_sched_pkg: shared types and widths for the render scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package render_sched_pkg;

  localparam int HC_W  = 11;  // raster column width
  localparam int VC_W  = 10;  // raster row width
  localparam int PIX_W = 17;  // returned-pixel counter width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Rows above the divide see every object; rows below only the cylinders.
  function automatic logic [1:0] region_select(input logic [VC_W-1:0] vcount,
                                               input logic [VC_W-1:0] divide);
    return (vcount < divide) ? 2'b11 : 2'b10;
  endfunction

endpackage

// File: rtl/render_scheduler_if.sv
// render_scheduler_if: coordinate issue and pixel return between scheduler and renderer.
// Latency: n/a (wires only).
// Backpressure: coord_ready_in stalls the coordinate; pixel_valid_in has no stall.
interface render_scheduler_if;
  import render_sched_pkg::*;

  logic [HC_W-1:0] hcount_out;
  logic [VC_W-1:0] vcount_out;
  logic            coord_valid_out;
  logic            coord_ready_in;
  logic [1:0]      select_objs_out;
  logic            pixel_valid_in;

  // Scheduler side.
  modport master (
    output hcount_out, vcount_out, coord_valid_out, select_objs_out,
    input  coord_ready_in, pixel_valid_in
  );

  // Renderer side.
  modport slave (
    input  hcount_out, vcount_out, coord_valid_out, select_objs_out,
    output coord_ready_in, pixel_valid_in
  );

endinterface

// File: rtl/render_scheduler_raster_stepper.sv
// raster_stepper: holds the current raster column/row and steps it left-to-right, top-to-bottom.
// Latency: new position visible the cycle after load/advance.
// Backpressure: position holds whenever advance is low.
module raster_stepper
  import render_sched_pkg::*;
#(
  parameter int START_X = 390,
  parameter int END_X   = 634,
  parameter int START_Y = 390,
  parameter int END_Y   = 765
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            load,
  input  logic            advance,
  output logic [HC_W-1:0] hcount,
  output logic [VC_W-1:0] vcount,
  output logic            last
);

  localparam logic [HC_W-1:0] X_FIRST = HC_W'(START_X);
  localparam logic [HC_W-1:0] X_LAST  = HC_W'(END_X - 1);
  localparam logic [VC_W-1:0] Y_FIRST = VC_W'(START_Y);
  localparam logic [VC_W-1:0] Y_LAST  = VC_W'(END_Y - 1);

  // Position register: origin on reset or load, column step with row wrap on advance.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      hcount <= X_FIRST;
      vcount <= Y_FIRST;
    end else if (load) begin
      hcount <= X_FIRST;
      vcount <= Y_FIRST;
    end else if (advance) begin
      if (hcount == X_LAST) begin
        hcount <= X_FIRST;
        vcount <= vcount + 1'b1;
      end else begin
        hcount <= hcount + 1'b1;
      end
    end
  end

  assign last = (hcount == X_LAST) && (vcount == Y_LAST);

endmodule

// File: rtl/render_scheduler.sv
// render_scheduler: one raster pass per frame_start_in, issuing coordinates and counting pixels back.
// Latency: first coordinate 1 cycle after frame_start_in; done_out 1 cycle after the last pixel counts.
// Backpressure: coordinate held while coord_ready_in low; RENDER_SCHED_WATCHDOG_EN adds a drain timeout.
module render_scheduler
  import render_sched_pkg::*;
#(
  parameter int START_X       = 390,
  parameter int END_X         = 634,
  parameter int START_Y       = 390,
  parameter int END_Y         = 765,
  parameter int REGION_DIVIDE = 530,
  parameter int SCENE_W       = 2112,
  parameter int WDOG_CYCLES   = 4096
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               frame_start_in,
  input  logic [SCENE_W-1:0] scene_in,
  render_scheduler_if.master bus,
  output logic [SCENE_W-1:0] scene_out,
  output logic               busy_out,
  output logic               done_out,
  output logic               buf_sel_out,
  output logic               overrun_out,
  output logic               timeout_out
);

  localparam int               TOTAL     = (END_X - START_X) * (END_Y - START_Y);
  localparam logic [PIX_W-1:0] PIX_TOTAL = PIX_W'(TOTAL);

  state_t           state;
  state_t           state_nxt;
  logic [PIX_W-1:0] pix_cnt;
  logic [HC_W-1:0]  hcount;
  logic [VC_W-1:0]  vcount;
  logic             raster_last;
  logic             coord_valid;
  logic             start;
  logic             handshake;
  logic             pix_take;
  logic             pix_done;
  logic             wdog_expire;

  assign start     = (state == ST_IDLE) && frame_start_in;
  assign handshake = coord_valid && bus.coord_ready_in;
  assign pix_done  = (pix_cnt == PIX_TOTAL);
  // Pixels only count while a pass is live, and never past the window size.
  assign pix_take  = ((state == ST_ISSUE) || (state == ST_DRAIN)) &&
                     bus.pixel_valid_in && !pix_done;

  // The final coordinate is not stepped past, so the position stays put until the next load.
  raster_stepper #(
    .START_X (START_X),
    .END_X   (END_X),
    .START_Y (START_Y),
    .END_Y   (END_Y)
  ) u_raster (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    (start),
    .advance (handshake && !raster_last),
    .hcount  (hcount),
    .vcount  (vcount),
    .last    (raster_last)
  );

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state: IDLE->ISSUE->DRAIN->DONE->IDLE, nothing else.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)                    state_nxt = ST_ISSUE;
      ST_ISSUE: if (handshake && raster_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (pix_done || wdog_expire)  state_nxt = ST_DONE;
      ST_DONE:                                state_nxt = ST_IDLE;
      default:                                state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; a start request mid-pass is reported and ignored.
  always_comb begin
    coord_valid = (state == ST_ISSUE);
    busy_out    = (state != ST_IDLE);
    done_out    = (state == ST_DONE);
    overrun_out = frame_start_in && (state != ST_IDLE);
  end

  assign bus.coord_valid_out = coord_valid;
  assign bus.hcount_out      = hcount;
  assign bus.vcount_out      = vcount;
  assign bus.select_objs_out = region_select(vcount, VC_W'(REGION_DIVIDE));

  // Per-pass datapath: scene snapshot at start, pixel counter, bank flip at DONE.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      scene_out   <= '0;
      pix_cnt     <= '0;
      buf_sel_out <= 1'b0;
    end else begin
      if (start) begin
        scene_out <= scene_in;
        pix_cnt   <= '0;
      end else if (pix_take) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
      if (state == ST_DONE) buf_sel_out <= ~buf_sel_out;
    end
  end

`ifdef RENDER_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] wdog_cnt;
  logic            timeout_q;

  // wdog_cnt is the number of cycles since the last pixel; the DONE cycle is the
  // WDOG_CYCLES-th silent one, so expiry fires when the count reaches WDOG_CYCLES-1.
  assign wdog_expire = (state == ST_DRAIN) && !bus.pixel_valid_in &&
                       (wdog_cnt >= WD_W'(WDOG_CYCLES - 1));

  // Silence counter runs only in DRAIN; the timeout flag is sticky until reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wdog_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state != ST_DRAIN) || bus.pixel_valid_in) wdog_cnt <= WD_W'(1);
      else                                           wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_expire) timeout_q <= 1'b1;
    end
  end

  assign timeout_out = timeout_q;
`else
  assign wdog_expire = 1'b0;
  assign timeout_out = 1'b0;
`endif

endmodule

// File: doc/render_scheduler.md
RENDER_SCHEDULER -- requirements
Module: render_scheduler

Interface
REQ-001 Parameter START_X, default 390, first raster column issued (11 bits).
REQ-002 Parameter END_X, default 634, column bound, exclusive.
REQ-003 Parameter START_Y, default 390, first raster row issued (10 bits).
REQ-004 Parameter END_Y, default 765, row bound, exclusive.
REQ-005 Parameter REGION_DIVIDE, default 530, row that splits the object-select regions.
REQ-006 Parameter SCENE_W, default 2112, scene vector width (sphere 192 + cylinders 1920).
REQ-007 Parameter WDOG_CYCLES, default 4096, drain timeout in cycles.
REQ-008 aclk  in  1  single clock; all logic is on the rising edge.
REQ-009 aresetn  in  1  reset, synchronous, active-low.
REQ-010 frame_start_in  in  1  one-cycle pulse requesting a render pass.
REQ-011 scene_in  in  SCENE_W  live scene parameters.
REQ-012 hcount_out  out  11  raster column to the renderer.
REQ-013 vcount_out  out  10  raster row to the renderer.
REQ-014 coord_valid_out  out  1  coordinate valid.
REQ-015 coord_ready_in  in  1  renderer accepts the coordinate.
REQ-016 select_objs_out  out  2  object select for the current coordinate.
REQ-017 scene_out  out  SCENE_W  scene snapshot held for the whole pass.
REQ-018 pixel_valid_in  in  1  renderer produced one pixel.
REQ-019 busy_out  out  1  pass in progress.
REQ-020 done_out  out  1  one-cycle pulse at the end of a pass.
REQ-021 buf_sel_out  out  1  framebuffer bank being written; toggles per pass.
REQ-022 overrun_out  out  1  one-cycle pulse when a frame_start_in is dropped.
REQ-023 timeout_out  out  1  sticky flag: the watchdog ended a pass.

Function
REQ-024 States IDLE, ISSUE, DRAIN, DONE; only transitions below are legal.
REQ-025 IDLE with frame_start_in: latch scene_in to scene_out, load START_X/START_Y, clear pixel counter, enter ISSUE next cycle.
REQ-026 ISSUE: coord_valid_out=1; on valid&ready hcount increments, wraps END_X-1 -> START_X with vcount+1.
REQ-027 Valid high and ready low: hcount_out, vcount_out and coord_valid_out hold unchanged (AXI stability).
REQ-028 Handshake of (END_X-1, END_Y-1): coord_valid_out deasserts next cycle; enter DRAIN.
REQ-029 select_objs_out = 2'b11 when vcount_out < REGION_DIVIDE, else 2'b10; combinational from vcount_out.
REQ-030 Pixel counter (17 bits) increments on pixel_valid_in in ISSUE and DRAIN, saturates at TOTAL=(END_X-START_X)*(END_Y-START_Y) (default 91500), ignored in IDLE/DONE.
REQ-031 DRAIN: counter == TOTAL -> DONE; if a pixel arrives on the last handshake cycle, DRAIN lasts exactly one cycle.
REQ-032 DONE: done_out=1 for one cycle, buf_sel_out toggles, return to IDLE.
REQ-033 busy_out=1 in ISSUE, DRAIN and DONE.
REQ-034 frame_start_in outside IDLE is dropped and overrun_out pulses the same cycle it arrives; the pass continues.
REQ-035 scene_out changes only on the IDLE->ISSUE latch.

Reset
REQ-036 aresetn low at an edge, including mid-pass: state IDLE, hcount_out=START_X, vcount_out=START_Y, coord_valid_out=0, scene_out=0, counter=0, busy_out=0, done_out=0, buf_sel_out=0, overrun_out=0, timeout_out=0.

Configuration
REQ-037 With RENDER_SCHED_WATCHDOG_EN defined: in DRAIN, WDOG_CYCLES consecutive cycles without pixel_valid_in force DONE and set timeout_out, which stays set until reset.
REQ-038 Without RENDER_SCHED_WATCHDOG_EN: no watchdog logic; DRAIN exits only on count; timeout_out is tied 0.

Structure
REQ-039 Package render_sched_pkg holds the state enum, coordinate widths (11/10) and the pixel-counter width (17).
REQ-040 Sub-module raster_stepper holds the hcount/vcount stepping and wrap logic, with a load/advance/last interface.

Verification (START_X=0, END_X=4, START_Y=0, END_Y=3, REGION_DIVIDE=2, ready tied 1, pixel returned 5 cycles after each handshake)
REQ-041 Single pass, frame_start pulse -> 12 coordinates (0,0)..(3,2) on consecutive cycles; select 11 for rows 0-1 and 10 for row 2; done_out pulses once after pixel 12; buf_sel_out 0->1.
REQ-042 Backpressure, ready low 3 cycles on coordinate (2,1) -> (2,1) held for 4 cycles; no skip or duplicate; 12 handshakes total.
REQ-043 Overrun, second frame_start at the 5th handshake -> overrun_out pulses once; one done_out only; scene_out keeps the first snapshot despite scene_in changing.
REQ-044 Reset mid-pass, aresetn low at the 7th handshake -> all outputs take their reset values next edge; the next frame_start starts again at (0,0) with buf_sel_out=0.
REQ-045 Watchdog with macro on (WDOG_CYCLES=8), only 11 pixels returned -> DONE 8 cycles after the last pixel, timeout_out=1; with macro off the scheduler stays in DRAIN and busy_out=1.
